qpu_itcm_ctrl: RTL and testbench

QPU_ITCM_CTRL -- requirements
Module: qpu_itcm_ctrl

---
 rtl/qpu_itcm_ctrl_pkg.sv | 17 +
 rtl/qpu_itcm_ctrl_ram.sv | 26 ++
 rtl/qpu_itcm_ctrl.sv | 120 ++++++++++++
 tb/tb_qpu_itcm_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qpu_itcm_ctrl_pkg.sv
// Shared constants and types for the QPU instruction TCM controller.
package qpu_itcm_ctrl_pkg;

   localparam int QPU_PC_SIZE     = 32;
   localparam int QPU_INSTR_SIZE  = 32;
   localparam int ITCM_AW_DEFAULT = 10;

   // Instruction word returned for a fetch from a bad address
   localparam logic [31:0] ERR_INSTR = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_HOLD = 2'd2
   } itcm_state_e;

endpackage

// File: rtl/qpu_itcm_ctrl_ram.sv
// Single-port ITCM array with a 1-cycle registered read; writes leave rdata unchanged.
module qpu_itcm_ram #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          cs,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (cs) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/qpu_itcm_ctrl.sv
// ITCM fetch controller: one outstanding IFU fetch, program-load writes have priority,
// stalled responses are parked in a holding register.
module qpu_itcm_ctrl
   import qpu_itcm_ctrl_pkg::*;
#(
   parameter int ITCM_AW = ITCM_AW_DEFAULT,
   parameter int PC_W    = QPU_PC_SIZE,
   parameter int INSTR_W = QPU_INSTR_SIZE
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ifu_req_valid,
   output logic               ifu_req_ready,
   input  logic [PC_W-1:0]    ifu_req_pc,
   input  logic               ifu_req_seq,
   output logic               ifu_rsp_valid,
   input  logic               ifu_rsp_ready,
   output logic [INSTR_W-1:0] ifu_rsp_instr,
   output logic               ifu_rsp_err,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [ITCM_AW-1:0] load_addr,
   input  logic [INSTR_W-1:0] load_data
);

   localparam logic [INSTR_W-1:0] ERR_WORD = INSTR_W'(ERR_INSTR);

   itcm_state_e       state_q, state_d;
   logic               req_hsk, req_bad;
   logic               err_q;
   logic [INSTR_W-1:0] hold_instr_q;
   logic               hold_err_q;
   logic [INSTR_W-1:0] rd_instr;
   logic               ram_cs, ram_we;
   logic [ITCM_AW-1:0] ram_addr;
   logic [INSTR_W-1:0] ram_rdata;
   logic               unused_ok;

   assign unused_ok = ifu_req_seq;

   // A fetch is only accepted when no load competes for the single SRAM port
   assign ifu_req_ready = ~load_valid & ((state_q == ST_IDLE) | ifu_rsp_ready);
   assign load_ready    = 1'b1;
   assign req_hsk       = ifu_req_valid & ifu_req_ready;
   assign req_bad       = (ifu_req_pc[1:0] != 2'b00) | (|ifu_req_pc[PC_W-1:ITCM_AW+2]);

   assign ram_cs   = load_valid | (req_hsk & ~req_bad);
   assign ram_we   = load_valid;
   assign ram_addr = load_valid ? load_addr : ifu_req_pc[ITCM_AW+1:2];

   qpu_itcm_ram #(
      .AW (ITCM_AW),
      .DW (INSTR_W)
   ) u_ram (
      .clk   (clk),
      .cs    (ram_cs),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (load_data),
      .rdata (ram_rdata)
   );

   assign rd_instr = err_q ? ERR_WORD : ram_rdata;

   // Every RD cycle snapshots the live response, so a stall (or a concurrent load)
   // leaves the pre-write read data parked for HOLD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         err_q        <= 1'b0;
         hold_instr_q <= '0;
         hold_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (req_hsk) begin
            err_q <= req_bad;
         end
         if (state_q == ST_RD) begin
            hold_instr_q <= rd_instr;
            hold_err_q   <= err_q;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ifu_rsp_valid = 1'b0;
      ifu_rsp_instr = '0;
      ifu_rsp_err   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_hsk) begin
               state_d = ST_RD;
            end
         end
         ST_RD: begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_instr = rd_instr;
            ifu_rsp_err   = err_q;
            if (ifu_rsp_ready) begin
               state_d = req_hsk ? ST_RD : ST_IDLE;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            ifu_rsp_valid = 1'b1;
            ifu_rsp_instr = hold_instr_q;
            ifu_rsp_err   = hold_err_q;
            if (ifu_rsp_ready) begin
               state_d = req_hsk ? ST_RD : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_qpu_itcm_ctrl.sv
// Directed self-checking bench for qpu_itcm_ctrl with hand-computed expectations.
module tb_qpu_itcm_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [31:0] ifu_req_pc;
   logic        ifu_req_seq;
   logic        ifu_rsp_valid;
   logic        ifu_rsp_ready;
   logic [31:0] ifu_rsp_instr;
   logic        ifu_rsp_err;
   logic        load_valid;
   logic        load_ready;
   logic [9:0]  load_addr;
   logic [31:0] load_data;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   qpu_itcm_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_req_pc    (ifu_req_pc),
      .ifu_req_seq   (ifu_req_seq),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_ready (ifu_rsp_ready),
      .ifu_rsp_instr (ifu_rsp_instr),
      .ifu_rsp_err   (ifu_rsp_err),
      .load_valid    (load_valid),
      .load_ready    (load_ready),
      .load_addr     (load_addr),
      .load_data     (load_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [9:0] a, input logic [31:0] d);
      load_valid = 1'b1;
      load_addr  = a;
      load_data  = d;
      settle();
      chk1("load_ready", load_ready, 1'b1);
      tick();
      load_valid = 1'b0;
   endtask

   task automatic idle_check(input string tag);
      chk1({tag, "_valid"}, ifu_rsp_valid, 1'b0);
      chk32({tag, "_instr"}, ifu_rsp_instr, 32'h0);
      chk1({tag, "_err"}, ifu_rsp_err, 1'b0);
   endtask

   initial begin
      rst           = 1'b1;
      ifu_req_valid = 1'b0;
      ifu_req_pc    = 32'h0;
      ifu_req_seq   = 1'b0;
      ifu_rsp_ready = 1'b0;
      load_valid    = 1'b0;
      load_addr     = 10'h0;
      load_data     = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      settle();
      idle_check("reset");
      chk1("reset_req_ready", ifu_req_ready, 1'b1);
      chk1("reset_load_ready", load_ready, 1'b1);

      // Load word 5 then fetch it at pc 0x14
      load_word(10'd5, 32'h1234_5678);
      ifu_req_valid = 1'b1;
      ifu_req_pc    = 32'h14;
      ifu_rsp_ready = 1'b1;
      settle();
      chk1("f14_req_ready", ifu_req_ready, 1'b1);
      chk1("f14_no_early_rsp", ifu_rsp_valid, 1'b0);
      tick();
      ifu_req_valid = 1'b0;
      settle();
      chk1("f14_valid", ifu_rsp_valid, 1'b1);
      chk32("f14_instr", ifu_rsp_instr, 32'h1234_5678);
      chk1("f14_err", ifu_rsp_err, 1'b0);
      tick();
      idle_check("f14_after");

      load_word(10'd0, 32'hA000_0000);
      load_word(10'd1, 32'hA111_1111);
      load_word(10'd2, 32'hA222_2222);
      load_word(10'd8, 32'hB888_8888);

      // Back-to-back fetches 0x0, 0x4, 0x8
      ifu_rsp_ready = 1'b1;
      ifu_req_valid = 1'b1;
      ifu_req_pc    = 32'h0;
      settle();
      chk1("b2b0_req_ready", ifu_req_ready, 1'b1);
      tick();
      ifu_req_pc = 32'h4;
      settle();
      chk1("b2b1_req_ready", ifu_req_ready, 1'b1);
      chk1("b2b1_valid", ifu_rsp_valid, 1'b1);
      chk32("b2b1_instr", ifu_rsp_instr, 32'hA000_0000);
      tick();
      ifu_req_pc = 32'h8;
      settle();
      chk1("b2b2_req_ready", ifu_req_ready, 1'b1);
      chk1("b2b2_valid", ifu_rsp_valid, 1'b1);
      chk32("b2b2_instr", ifu_rsp_instr, 32'hA111_1111);
      tick();
      ifu_req_valid = 1'b0;
      settle();
      chk1("b2b3_valid", ifu_rsp_valid, 1'b1);
      chk32("b2b3_instr", ifu_rsp_instr, 32'hA222_2222);
      tick();
      idle_check("b2b_after");

      // Stall: fetch 0x20, rsp_ready low for three cycles
      ifu_req_valid = 1'b1;
      ifu_req_pc    = 32'h20;
      ifu_rsp_ready = 1'b0;
      tick();
      ifu_req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk1("stall_valid", ifu_rsp_valid, 1'b1);
         chk32("stall_instr", ifu_rsp_instr, 32'hB888_8888);
         chk1("stall_req_ready", ifu_req_ready, 1'b0);
         tick();
      end
      ifu_rsp_ready = 1'b1;
      settle();
      chk1("stall_rel_valid", ifu_rsp_valid, 1'b1);
      chk32("stall_rel_instr", ifu_rsp_instr, 32'hB888_8888);
      chk1("stall_rel_req_ready", ifu_req_ready, 1'b1);
      tick();
      idle_check("stall_after");

      // Bad addresses: misaligned and out of range
      ifu_req_valid = 1'b1;
      ifu_req_pc    = 32'h2;
      tick();
      ifu_req_pc = 32'h1000;
      settle();
      chk1("bad2_valid", ifu_rsp_valid, 1'b1);
      chk32("bad2_instr", ifu_rsp_instr, 32'h0);
      chk1("bad2_err", ifu_rsp_err, 1'b1);
      tick();
      ifu_req_valid = 1'b0;
      settle();
      chk1("bad1000_valid", ifu_rsp_valid, 1'b1);
      chk32("bad1000_instr", ifu_rsp_instr, 32'h0);
      chk1("bad1000_err", ifu_rsp_err, 1'b1);
      tick();
      idle_check("bad_after");

      // Reset during a stalled RD response
      ifu_req_valid = 1'b1;
      ifu_req_pc    = 32'h0;
      ifu_rsp_ready = 1'b0;
      tick();
      ifu_req_valid = 1'b0;
      rst           = 1'b1;
      settle();
      chk1("rst_rd_valid", ifu_rsp_valid, 1'b1);
      tick();
      rst = 1'b0;
      settle();
      idle_check("rst_after");
      chk1("rst_after_req_ready", ifu_req_ready, 1'b1);
      tick();
      idle_check("rst_no_stale");

      // Load concurrent with fetch request, then fetch the new word
      ifu_rsp_ready = 1'b1;
      ifu_req_valid = 1'b1;
      ifu_req_pc    = 32'hC;
      load_valid    = 1'b1;
      load_addr     = 10'd3;
      load_data     = 32'hC333_3333;
      settle();
      chk1("ld_conc_req_ready", ifu_req_ready, 1'b0);
      chk1("ld_conc_load_ready", load_ready, 1'b1);
      tick();
      load_valid = 1'b0;
      settle();
      chk1("raw_req_ready", ifu_req_ready, 1'b1);
      chk1("raw_no_rsp", ifu_rsp_valid, 1'b0);
      tick();
      ifu_req_valid = 1'b0;
      settle();
      chk1("raw_valid", ifu_rsp_valid, 1'b1);
      chk32("raw_instr", ifu_rsp_instr, 32'hC333_3333);
      tick();

      // Load overwrites the word of a stalled response: old data must be returned
      ifu_req_valid = 1'b1;
      ifu_req_pc    = 32'h4;
      ifu_rsp_ready = 1'b0;
      tick();
      ifu_req_valid = 1'b0;
      load_valid    = 1'b1;
      load_addr     = 10'd1;
      load_data     = 32'hD111_1111;
      settle();
      chk32("ldrd_rd_instr", ifu_rsp_instr, 32'hA111_1111);
      tick();
      load_valid    = 1'b0;
      ifu_rsp_ready = 1'b1;
      settle();
      chk1("ldrd_hold_valid", ifu_rsp_valid, 1'b1);
      chk32("ldrd_hold_instr", ifu_rsp_instr, 32'hA111_1111);
      tick();
      ifu_req_valid = 1'b1;
      ifu_req_pc    = 32'h4;
      tick();
      ifu_req_valid = 1'b0;
      settle();
      chk32("ldrd_new_instr", ifu_rsp_instr, 32'hD111_1111);
      chk1("ldrd_new_err", ifu_rsp_err, 1'b0);
      tick();
      idle_check("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
